// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one spi_master between NUM_REQ requesters.
// Optional watchdog on missing spi_done is built when SPI_ARB_TIMEOUT_EN is defined.
module spi_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_LENGTH    = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [DATA_LENGTH-1:0]         rsp_data,
   output logic                           rsp_err,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id,
   output logic                           active,
   output logic                           spi_start,
   output logic [DATA_LENGTH-1:0]         spi_data_in,
   input  logic [DATA_LENGTH-1:0]         spi_data_out,
   input  logic                           spi_busy,
   input  logic                           spi_done
);

   localparam int IW = $clog2(NUM_REQ);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [1:0]             r_state;
   logic [IW-1:0]          r_last;
   logic [IW-1:0]          r_grant;
   logic [NUM_REQ-1:0]     r_ready;
   logic [NUM_REQ-1:0]     r_rsp_valid;
   logic [DATA_LENGTH-1:0] r_rsp_data;
   logic [DATA_LENGTH-1:0] r_data_in;
   logic                   r_start;
   logic                   r_active;

   logic [IW-1:0]          w_win;
   logic [IW-1:0]          w_cand;
   logic                   w_found;
   logic [DATA_LENGTH-1:0] w_word;
   logic                   w_expired;

   // Round-robin pick: scan last+1 .. last, first valid request wins
   always_comb begin
      w_win   = r_last;
      w_cand  = r_last;
      w_found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_cand = IW'((int'(r_last) + i) % NUM_REQ);
         if (!w_found && req_valid[w_cand]) begin
            w_win   = w_cand;
            w_found = 1'b1;
         end
      end
   end

   assign w_word = req_data[w_win*DATA_LENGTH +: DATA_LENGTH];

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] r_wdog;
   logic          r_rsp_err;

   // Watchdog counts WAIT cycles; held at zero elsewhere so it starts clean
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wdog <= '0;
      end else if (r_state != S_WAIT) begin
         r_wdog <= '0;
      end else begin
         r_wdog <= r_wdog + TW'(1);
      end
   end

   assign w_expired = (r_wdog == TW'(TIMEOUT_CYCLES - 1));
   assign rsp_err   = r_rsp_err;
`else
   logic w_unused_timeout;

   assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
   assign w_expired        = 1'b0;
   assign rsp_err          = 1'b0;
`endif

   // Sequencer: arbitrate, issue one start, wait for done, return response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_last      <= IW'(NUM_REQ - 1);
         r_grant     <= '0;
         r_ready     <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_data_in   <= '0;
         r_start     <= 1'b0;
         r_active    <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
         r_rsp_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|req_valid && !spi_busy) begin
                  r_grant   <= w_win;
                  r_data_in <= w_word;
                  r_ready   <= ONE << w_win;
                  r_start   <= 1'b1;
                  r_active  <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_start <= 1'b0;
               r_ready <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (spi_done) begin
                  r_rsp_data  <= spi_data_out;
                  r_rsp_valid <= ONE << r_grant;
                  r_state     <= S_RESP;
               end else if (w_expired) begin
                  r_rsp_data  <= '0;
                  r_rsp_valid <= ONE << r_grant;
`ifdef SPI_ARB_TIMEOUT_EN
                  r_rsp_err   <= 1'b1;
`endif
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               r_rsp_valid <= '0;
               r_last      <= r_grant;
               r_active    <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
               r_rsp_err   <= 1'b0;
`endif
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready   = r_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_data    = r_rsp_data;
   assign grant_id    = r_grant;
   assign active      = r_active;
   assign spi_start   = r_start;
   assign spi_data_in = r_data_in;

endmodule
